fetch_sequencer: RTL and testbench

- Instruction-fetch controller for the pipelined CPU; owns the program counter driven into the combinational instruction ROM.
- Registers each fetched 9-bit instruction (5-bit opcode, 4-bit operand) and its PC into the IF/ID pipeline register.
- Applies stalls and branch/jump redirects from later stages.
- Detects the halt opcode, drains the pipeline, then freezes fetch.

---
 rtl/cpu_isa_pkg.sv | 38 +++
 rtl/fetch_pc_reg.sv | 40 ++++
 rtl/fetch_sequencer.sv | 144 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the pipelined CPU: field widths, opcode map,
// and the fetch-stage state encoding.
package cpu_isa_pkg;

    localparam int OPCODE_W  = 5;
    localparam int OPERAND_W = 4;
    localparam int INSTR_W   = OPCODE_W + OPERAND_W;
    localparam int PC_W      = 16;

    // Full opcode map, add..halt
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b00110;
    localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00111;
    localparam logic [OPCODE_W-1:0] OP_ST   = 5'b01000;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b01001;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 5'b01010;
    localparam logic [OPCODE_W-1:0] OP_BNE  = 5'b01011;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 5'b01100;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b01101;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11010;

    typedef enum logic [1:0] {
        FS_BOOT   = 2'd0,
        FS_RUN    = 2'd1,
        FS_DRAIN  = 2'd2,
        FS_HALTED = 2'd3
    } fetch_state_e;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1:OPERAND_W];
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC selection.
// Priority: redirect > advance (pc+1, 16-bit wrap) > hold.
module fetch_pc_reg
    import cpu_isa_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'd1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    input  logic            advance_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Next-PC mux; increment wraps silently at 16'hFFFF
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            pc_d = pc_q + 16'd1;
        end
    end

    // PC state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fills the IF/ID register,
// honours stall/redirect, and drains then freezes on the halt opcode.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_sequencer
    import cpu_isa_pkg::*;
#(
    parameter logic [PC_W-1:0]     RESET_PC     = 16'd1,
    parameter int                  DRAIN_CYCLES = 3,
    parameter logic [OPCODE_W-1:0] HALT_OP      = OP_HALT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    rom_pc,
    input  logic [INSTR_W-1:0] rom_instr,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
`ifdef FETCH_PERF_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall,
`endif
    output logic               halted
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    fetch_state_e       state_q;
    logic [CNT_W-1:0]   drain_cnt_q;
    logic [INSTR_W-1:0] if_id_instr_q;
    logic [PC_W-1:0]    if_id_pc_q;
    logic               if_id_valid_q;
    logic               halted_q;

    logic            is_halt;
    logic            take_redirect;
    logic            fetch_en;
    logic            advance;
    logic [PC_W-1:0] pc;

    // Decode this cycle's fetch decision from state and downstream requests
    always_comb begin
        is_halt       = (opcode_of(rom_instr) == HALT_OP);
        take_redirect = redirect_valid && (state_q == FS_RUN || state_q == FS_DRAIN);
        fetch_en      = (state_q == FS_RUN) && !redirect_valid && !stall;
        advance       = fetch_en && !is_halt;
    end

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (take_redirect),
        .redirect_pc_i (redirect_pc),
        .advance_i     (advance),
        .pc_o          (pc)
    );

    // Fetch FSM together with the IF/ID pipeline register and halt flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FS_BOOT;
            drain_cnt_q   <= '0;
            if_id_instr_q <= '0;
            if_id_pc_q    <= '0;
            if_id_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state_q)
                FS_BOOT: begin
                    state_q <= FS_RUN;
                end
                FS_RUN: begin
                    if (redirect_valid) begin
                        if_id_valid_q <= 1'b0;
                    end else if (!stall) begin
                        if_id_instr_q <= rom_instr;
                        if_id_pc_q    <= pc;
                        if_id_valid_q <= 1'b1;
                        if (is_halt) begin
                            state_q     <= FS_DRAIN;
                            drain_cnt_q <= '0;
                        end
                    end
                end
                FS_DRAIN: begin
                    // Stall does not pause draining; an older redirect cancels the halt
                    if_id_valid_q <= 1'b0;
                    if (redirect_valid) begin
                        state_q     <= FS_RUN;
                        drain_cnt_q <= '0;
                    end else if (drain_cnt_q == DRAIN_LAST) begin
                        state_q  <= FS_HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    if_id_valid_q <= 1'b0;
                    halted_q      <= 1'b1;
                end
            endcase
        end
    end

    assign rom_pc      = pc;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_valid = if_id_valid_q;
    assign halted      = halted_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating event counters; both events are impossible in HALTED
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (fetch_en) begin
                perf_fetched_q <= sat_inc(perf_fetched_q);
            end
            if (state_q == FS_RUN && stall && !redirect_valid) begin
                perf_stall_q <= sat_inc(perf_stall_q);
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small combinational ROM model.
module tb_fetch_sequencer;
    import cpu_isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] rom_pc;
    logic [8:0]  rom_instr;
    logic [8:0]  if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_pc         (rom_pc),
        .rom_instr      (rom_instr),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_valid    (if_id_valid),
`ifdef FETCH_PERF_EN
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
`endif
        .halted         (halted)
    );

    // Bench program: 1..12 ordinary ops, 13 jump, 14 halt, everything else 0
    function automatic logic [8:0] rom_word(input logic [15:0] a);
        logic [15:0] m;
        m = a % 16'd5;
        if (a >= 16'd1 && a <= 16'd12) return {m[4:0], a[3:0]};
        else if (a == 16'd13)          return {OP_JMP, 4'd1};
        else if (a == 16'd14)          return {OP_HALT, 4'd0};
        else                           return 9'd0;
    endfunction

    always_comb rom_instr = rom_word(rom_pc);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'd0;
        tick(); tick();
        tests++; if (rom_pc !== 16'd1) begin fails++; $display("FAIL reset_rom_pc got %h want 0001", rom_pc); end
        tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", if_id_valid); end
        tests++; if (if_id_pc !== 16'd0 || if_id_instr !== 9'd0) begin fails++; $display("FAIL reset_ifid got pc=%h instr=%h want 0/0", if_id_pc, if_id_instr); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b want 0", halted); end
        rst = 1'b0;
        tick();  // BOOT
        tests++; if (rom_pc !== 16'd1 || if_id_valid !== 1'b0) begin fails++; $display("FAIL boot got pc=%h v=%b want 0001/0", rom_pc, if_id_valid); end
        tick();  // first capture
        tests++; if (if_id_pc !== 16'd1 || if_id_valid !== 1'b1 || if_id_instr !== rom_word(16'd1) || rom_pc !== 16'd2) begin
            fails++; $display("FAIL first_fetch got ifpc=%h v=%b instr=%h rom_pc=%h want 0001/1/%h/0002", if_id_pc, if_id_valid, if_id_instr, rom_pc, rom_word(16'd1)); end
        tick();
        tests++; if (if_id_pc !== 16'd2 || if_id_instr !== rom_word(16'd2) || rom_pc !== 16'd3) begin
            fails++; $display("FAIL second_fetch got ifpc=%h instr=%h rom_pc=%h want 0002/%h/0003", if_id_pc, if_id_instr, rom_pc, rom_word(16'd2)); end
    endtask

    task automatic test_stall();
        tick(); tick();  // if_id=4, rom_pc=5
        tests++; if (rom_pc !== 16'd5 || if_id_pc !== 16'd4) begin fails++; $display("FAIL pre_stall got rom_pc=%h ifpc=%h want 0005/0004", rom_pc, if_id_pc); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (rom_pc !== 16'd5 || if_id_pc !== 16'd4 || if_id_valid !== 1'b1) begin
                fails++; $display("FAIL stall_hold cyc=%0d got rom_pc=%h ifpc=%h v=%b want 0005/0004/1", i, rom_pc, if_id_pc, if_id_valid); end
        end
        stall = 1'b0;
        tick();
        tests++; if (if_id_pc !== 16'd5 || rom_pc !== 16'd6 || if_id_valid !== 1'b1) begin
            fails++; $display("FAIL stall_resume got ifpc=%h rom_pc=%h v=%b want 0005/0006/1", if_id_pc, rom_pc, if_id_valid); end
    endtask

    task automatic test_redirect_stall();
        tick(); tick(); tick();  // if_id=8, rom_pc=9
        tests++; if (rom_pc !== 16'd9) begin fails++; $display("FAIL pre_redirect got rom_pc=%h want 0009", rom_pc); end
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'd1;
        tick();
        stall = 1'b0; redirect_valid = 1'b0;
        tests++; if (rom_pc !== 16'd1 || if_id_valid !== 1'b0) begin fails++; $display("FAIL redirect_flush got rom_pc=%h v=%b want 0001/0", rom_pc, if_id_valid); end
        tick();
        tests++; if (if_id_pc !== 16'd1 || if_id_valid !== 1'b1 || rom_pc !== 16'd2) begin
            fails++; $display("FAIL redirect_refetch got ifpc=%h v=%b rom_pc=%h want 0001/1/0002", if_id_pc, if_id_valid, rom_pc); end
    endtask

    task automatic test_halt();
        int guard;
        guard = 0;
        while (rom_pc !== 16'd14 && guard < 40) begin tick(); guard++; end
        tests++; if (rom_pc !== 16'd14) begin fails++; $display("FAIL reach_halt_pc got %h want 000e", rom_pc); end
        tick();  // halt captured
        tests++; if (if_id_pc !== 16'd14 || if_id_valid !== 1'b1 || if_id_instr !== {OP_HALT, 4'd0} || rom_pc !== 16'd14 || halted !== 1'b0) begin
            fails++; $display("FAIL halt_capture got ifpc=%h v=%b instr=%h rom_pc=%h h=%b want 000e/1/1a0/000e/0", if_id_pc, if_id_valid, if_id_instr, rom_pc, halted); end
        stall = 1'b1;  // draining must not pause
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (if_id_valid !== 1'b0 || rom_pc !== 16'd14 || halted !== (i == 2)) begin
                fails++; $display("FAIL drain cyc=%0d got v=%b rom_pc=%h h=%b want 0/000e/%b", i, if_id_valid, rom_pc, halted, (i == 2)); end
        end
        stall = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 16'd3;
        tick(); tick();
        redirect_valid = 1'b0;
        tests++; if (halted !== 1'b1 || rom_pc !== 16'd14 || if_id_pc !== 16'd14 || if_id_valid !== 1'b0) begin
            fails++; $display("FAIL halted_frozen got h=%b rom_pc=%h ifpc=%h v=%b want 1/000e/000e/0", halted, rom_pc, if_id_pc, if_id_valid); end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        #1;  // well before the next rising edge
        tests++; if (rom_pc !== 16'd1 || halted !== 1'b0 || if_id_valid !== 1'b0 || if_id_pc !== 16'd0 || if_id_instr !== 9'd0) begin
            fails++; $display("FAIL async_reset got rom_pc=%h h=%b v=%b ifpc=%h instr=%h want 0001/0/0/0000/000", rom_pc, halted, if_id_valid, if_id_pc, if_id_instr); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_drain_redirect();
        tick();  // BOOT -> RUN
        redirect_valid = 1'b1; redirect_pc = 16'd14;
        tick();
        redirect_valid = 1'b0;
        tests++; if (rom_pc !== 16'd14 || if_id_valid !== 1'b0) begin fails++; $display("FAIL jump_to_halt got rom_pc=%h v=%b want 000e/0", rom_pc, if_id_valid); end
        tick();  // halt captured
        tick();  // first drain cycle done
        redirect_valid = 1'b1; redirect_pc = 16'd2;
        tick();
        redirect_valid = 1'b0;
        tests++; if (rom_pc !== 16'd2 || if_id_valid !== 1'b0 || halted !== 1'b0) begin
            fails++; $display("FAIL drain_redirect got rom_pc=%h v=%b h=%b want 0002/0/0", rom_pc, if_id_valid, halted); end
        tick();
        tests++; if (if_id_pc !== 16'd2 || if_id_valid !== 1'b1 || rom_pc !== 16'd3) begin
            fails++; $display("FAIL resume_after_drain got ifpc=%h v=%b rom_pc=%h want 0002/1/0003", if_id_pc, if_id_valid, rom_pc); end
        tick(); tick(); tick();
        tests++; if (if_id_pc !== 16'd5 || halted !== 1'b0) begin fails++; $display("FAIL run_continues got ifpc=%h h=%b want 0005/0", if_id_pc, halted); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        redirect_valid = 1'b0;
        tests++; if (rom_pc !== 16'hFFFF) begin fails++; $display("FAIL wrap_target got rom_pc=%h want ffff", rom_pc); end
        tick();
        tests++; if (if_id_pc !== 16'hFFFF || if_id_instr !== 9'd0 || if_id_valid !== 1'b1 || rom_pc !== 16'h0000) begin
            fails++; $display("FAIL wrap got ifpc=%h instr=%h v=%b rom_pc=%h want ffff/000/1/0000", if_id_pc, if_id_instr, if_id_valid, rom_pc); end
        tick();
        tests++; if (if_id_pc !== 16'h0000 || if_id_valid !== 1'b1 || rom_pc !== 16'h0001) begin
            fails++; $display("FAIL after_wrap got ifpc=%h v=%b rom_pc=%h want 0000/1/0001", if_id_pc, if_id_valid, rom_pc); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_stall();
        test_halt();
        test_async_reset();
        test_drain_redirect();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
